if_stage: RTL

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register. It consumes the branch-decision signal `PCSrc` (Branch AND Zero, produced in MEM) together with the branch target, and the `Stall` request from the hazard unit. On a taken branch it redirects the PC and flushes IF/ID; on a misaligned target it halts fetch until reset.

---
 rtl/if_stage.sv | 77 +++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: owns the PC, drives IMEM address and the IF/ID register; define IF_PERF_CNT_EN for fetch/flush counters
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PCSrc,
   input  logic [31:0] BranchTarget,
   input  logic        Stall,
   output logic [31:0] IMemAddr,
   input  logic [31:0] IMemData,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid,
   output logic        Halted
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] FlushCount
`endif
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misalign;
   logic        flush;
   logic        fetch;
   logic        bubble;
   assign pc_plus4 = pc + 32'd4;
   assign IMemAddr = pc;
   assign misalign = state == RUN && PCSrc && |BranchTarget[1:0];
   assign flush    = state == RUN && PCSrc && ~|BranchTarget[1:0];
   assign fetch    = state == RUN && !PCSrc && !Stall;
   assign bubble   = misalign || flush || state == HALT;
   // FSM: BOOT for one edge, RUN fetches/redirects/stalls, HALT bubbles until reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         IFID_Instr   <= NOP_INSTR;
         IFID_PCPlus4 <= 32'd0;
         IFID_Valid   <= 1'b0;
         Halted       <= 1'b0;
      end else begin
         if (state == BOOT) state <= RUN;
         if (misalign) begin
            state  <= HALT;
            Halted <= 1'b1;
         end
         if (flush) pc <= BranchTarget;
         if (fetch) begin
            pc           <= pc_plus4;
            IFID_Instr   <= IMemData;
            IFID_PCPlus4 <= pc_plus4;
            IFID_Valid   <= 1'b1;
         end else if (bubble) begin
            IFID_Instr   <= NOP_INSTR;
            IFID_PCPlus4 <= 32'd0;
            IFID_Valid   <= 1'b0;
         end
      end
   end
`ifdef IF_PERF_CNT_EN
   // performance counters: valid loads and aligned redirects, frozen in HALT by construction
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         FetchCount <= 32'd0;
         FlushCount <= 32'd0;
      end else begin
         if (fetch) FetchCount <= FetchCount + 32'd1;
         if (flush) FlushCount <= FlushCount + 32'd1;
      end
   end
`endif
endmodule
